// File: rtl/uart_frame_rx.sv
// uart_frame_rx: reassembles 4-byte big-endian UART frames into one 32-bit word with timeout, error count and link status
module uart_frame_rx #(
  parameter int          TIMEOUT_CYCLES = 100_000,
  parameter int          LINK_TICKS     = 8,
  parameter logic [31:0] RESET_WORD     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic [7:0]  rx_data,
  input  logic        rx_done_tick,
  output logic [31:0] rx_buf,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        link_up
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LINK_TICKS + 1);
  typedef enum logic [1:0] {WAIT_SYNC, GET_B1, GET_B2, GET_B3} state_t;
  state_t state, state_n;
  logic [23:0] sh, sh_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [LW-1:0] lcnt;
  logic [31:0] buf_n;
  logic fv_n, fe_n;
  always_ff @(posedge clk)
    if (rst) state <= WAIT_SYNC;
    else state <= state_n;
  // sh accumulates bytes 0..2; rx_buf is only written once the 4th byte arrives
  always_comb begin
    state_n = state;
    sh_n = sh;
    buf_n = rx_buf;
    fv_n = 1'b0;
    fe_n = 1'b0;
    tcnt_n = '0;
    if (state == WAIT_SYNC) begin
      if (rx_done_tick) begin
        sh_n = {sh[15:0], rx_data};
        state_n = rx_data[7] ? GET_B1 : WAIT_SYNC;
        fe_n = ~rx_data[7];
      end
    end else if (rx_done_tick) begin
      sh_n = {sh[15:0], rx_data};
      state_n = (state == GET_B1) ? GET_B2 : (state == GET_B2) ? GET_B3 : WAIT_SYNC;
      fv_n = (state == GET_B3);
      buf_n = fv_n ? {sh, rx_data} : rx_buf;
    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      fe_n = 1'b1;
      state_n = WAIT_SYNC;
    end else begin
      tcnt_n = tcnt + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      sh <= '0;
      tcnt <= '0;
      lcnt <= '0;
      rx_buf <= RESET_WORD;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      err_cnt <= '0;
      link_up <= 1'b0;
    end else begin
      sh <= sh_n;
      tcnt <= tcnt_n;
      rx_buf <= buf_n;
      frame_valid <= fv_n;
      frame_err <= fe_n;
      err_cnt <= (fe_n && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
      lcnt <= fv_n ? '0 : (timing_tick && lcnt != LW'(LINK_TICKS)) ? lcnt + 1'b1 : lcnt;
      link_up <= fv_n | (link_up & ~(timing_tick && lcnt >= LW'(LINK_TICKS - 1)));
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: table-driven frames plus hand sequences, frames checked through a scoreboard queue
module tb_uart_frame_rx;
  localparam int T = 40;
  localparam int L = 8;
  localparam logic [31:0] RW = 32'hDEADBEEF;
  logic clk = 1'b0;
  logic rst, timing_tick, rx_done_tick;
  logic [7:0] rx_data;
  logic [31:0] rx_buf;
  logic frame_valid, frame_err, link_up;
  logic [7:0] err_cnt;
  int tests = 0, fails = 0, err_seen = 0, exp_err = 0, e0;
  logic [31:0] q[$];
  typedef struct {
    logic [47:0] seq;
    int n;
    int gap;
    logic [31:0] exp_buf;
    int n_err;
  } vec_t;
  vec_t vt[5];

  uart_frame_rx #(.TIMEOUT_CYCLES(T), .LINK_TICKS(L), .RESET_WORD(RW)) dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .rx_data(rx_data),
    .rx_done_tick(rx_done_tick), .rx_buf(rx_buf), .frame_valid(frame_valid),
    .frame_err(frame_err), .err_cnt(err_cnt), .link_up(link_up)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_tick();
    timing_tick = 1'b1;
    @(negedge clk);
    timing_tick = 1'b0;
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (frame_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: rx_buf=%h with no frame expected", rx_buf);
        end else begin
          chk("frame", rx_buf, q.pop_front());
        end
      end
      if (frame_err) err_seen++;
      if (frame_valid && frame_err) chk("valid_err_exclusive", 32'd1, 32'd0);
    end

  initial begin
    vt[0] = '{48'h8A5C33F1_0000, 4, 10, 32'h8A5C33F1, 0};
    vt[1] = '{48'h128A000001_00, 5, 3, 32'h8A000001, 1};
    vt[2] = '{48'hFF00FF00_0000, 4, 0, 32'hFF00FF00, 0};
    vt[3] = '{48'h7F807FFF80_00, 5, 1, 32'h807FFF80, 1};
    vt[4] = '{48'h0000C1234567, 6, 2, 32'hC1234567, 2};
    rst = 1'b1;
    timing_tick = 1'b0;
    rx_done_tick = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_buf", rx_buf, RW);
    chk("reset_valid", {31'b0, frame_valid}, 32'd0);
    chk("reset_err", {31'b0, frame_err}, 32'd0);
    chk("reset_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("reset_link", {31'b0, link_up}, 32'd0);
    rst = 1'b0;
    foreach (vt[k]) begin
      e0 = err_seen;
      for (int i = 0; i < vt[k].n; i++) begin
        if (i == vt[k].n - 1) q.push_back(vt[k].exp_buf);
        send_byte(vt[k].seq[47-8*i -: 8], vt[k].gap);
      end
      repeat (2) @(negedge clk);
      chk("vec_buf", rx_buf, vt[k].exp_buf);
      chk("vec_errs", err_seen - e0, vt[k].n_err);
      exp_err += vt[k].n_err;
      chk("vec_err_cnt", {24'b0, err_cnt}, exp_err);
      chk("vec_link", {31'b0, link_up}, 32'd1);
    end
    e0 = err_seen;
    send_byte(8'h8A, 0);
    send_byte(8'h5C, T);
    repeat (2) @(negedge clk);
    chk("timeout_err", err_seen - e0, 32'd1);
    chk("timeout_buf_held", rx_buf, 32'hC1234567);
    exp_err += 1;
    chk("timeout_err_cnt", {24'b0, err_cnt}, exp_err);
    q.push_back(32'h80000000);
    send_byte(8'h80, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 2);
    chk("after_timeout_buf", rx_buf, 32'h80000000);
    e0 = err_seen;
    send_byte(8'hA1, T - 1);
    send_byte(8'hB2, T - 1);
    send_byte(8'hC3, T - 1);
    chk("no_partial_buf", rx_buf, 32'h80000000);
    q.push_back(32'hA1B2C3D4);
    send_byte(8'hD4, 0);
    chk("latency_valid", {31'b0, frame_valid}, 32'd1);
    @(negedge clk);
    chk("valid_one_cycle", {31'b0, frame_valid}, 32'd0);
    chk("edge_timeout_buf", rx_buf, 32'hA1B2C3D4);
    chk("edge_timeout_errs", err_seen - e0, 32'd0);
    send_byte(8'h8A, 1);
    send_byte(8'h5C, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_buf", rx_buf, RW);
    chk("midrst_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("midrst_link", {31'b0, link_up}, 32'd0);
    e0 = err_seen;
    send_byte(8'h33, 1);
    send_byte(8'h11, 1);
    q.push_back(32'h9ABCDEF0);
    send_byte(8'h9A, 1);
    send_byte(8'hBC, 1);
    send_byte(8'hDE, 1);
    send_byte(8'hF0, 2);
    chk("midrst_frame", rx_buf, 32'h9ABCDEF0);
    chk("midrst_errs", err_seen - e0, 32'd2);
    chk("midrst_err_cnt2", {24'b0, err_cnt}, 32'd2);
    chk("link_after_frame", {31'b0, link_up}, 32'd1);
    repeat (L - 1) pulse_tick();
    chk("link_before_drop", {31'b0, link_up}, 32'd1);
    pulse_tick();
    chk("link_dropped", {31'b0, link_up}, 32'd0);
    send_byte(8'h81, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    q.push_back(32'h81020304);
    timing_tick = 1'b1;
    send_byte(8'h04, 0);
    timing_tick = 1'b0;
    chk("link_valid_wins", {31'b0, link_up}, 32'd1);
    repeat (L - 1) pulse_tick();
    chk("link_hold_after_tie", {31'b0, link_up}, 32'd1);
    pulse_tick();
    chk("link_drop_after_tie", {31'b0, link_up}, 32'd0);
    e0 = err_seen;
    repeat (300) send_byte(8'h01, 0);
    repeat (2) @(negedge clk);
    chk("sat_err_cnt", {24'b0, err_cnt}, 32'hFF);
    chk("sat_err_pulses", err_seen - e0, 32'd300);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
